// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: loads a byte-stream program image into instruction RAM and gates core fetches.
// Optional feature macro IMEM_LOAD_CHECKSUM_EN: the last byte is an 8-bit checksum instead of data.
module imem_load_ctrl #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7,
    parameter logic [31:0] NOP    = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    input  logic [31:0]       fetch_a,
    output logic [31:0]       mem_a,
    input  logic [31:0]       mem_rd,
    output logic [31:0]       instr,
    output logic              fetch_fault,
    output logic              cpu_stall,
    output logic              cpu_rst,
    output logic              load_err,
    output logic [ADDR_W:0]   load_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] ERR  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] w_waddr_nxt;
    logic [7:0]        r_wdata;
    logic [7:0]        w_wdata_nxt;
    logic              r_cpu_rst;
    logic              w_cpu_rst_nxt;
    logic              w_full;
    logic              w_accept;
    logic              w_run_live;
    logic              w_fetch_ok;
    logic [32:0]       w_fetch_end;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]        r_sum;
    logic [7:0]        w_sum_nxt;
    logic [7:0]        w_sum_chk;
`endif

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign byte_ready = (r_state == LOAD) && !load_req;
    assign w_accept   = byte_valid && byte_ready;

    // Next-state and write-path decode
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
`ifdef IMEM_LOAD_CHECKSUM_EN
        w_sum_nxt   = r_sum;
        w_sum_chk   = r_sum + byte_data;
`endif
        if (load_req) begin
            w_state_nxt = LOAD;
            w_count_nxt = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            w_sum_nxt   = '0;
`endif
        end else if (w_accept) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            if (byte_last) begin
                w_state_nxt = (w_sum_chk == 8'd0) ? RUN : ERR;
            end else if (w_full) begin
                w_state_nxt = ERR;
            end else begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = r_count[ADDR_W-1:0];
                w_wdata_nxt = byte_data;
                w_count_nxt = r_count + CNT_W'(1);
                w_sum_nxt   = w_sum_chk;
            end
`else
            if (w_full) begin
                w_state_nxt = ERR;
            end else begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = r_count[ADDR_W-1:0];
                w_wdata_nxt = byte_data;
                w_count_nxt = r_count + CNT_W'(1);
                if (byte_last) begin
                    w_state_nxt = RUN;
                end
            end
`endif
        end
        w_cpu_rst_nxt = (r_state == LOAD) && (w_state_nxt == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= LOAD;
            r_count   <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_cpu_rst <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_we      <= w_we_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_cpu_rst <= w_cpu_rst_nxt;
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum_nxt;
        end
    end
`endif

    assign mem_we     = r_we;
    assign mem_waddr  = r_waddr;
    assign mem_wdata  = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign cpu_stall  = (r_state != RUN);
    assign load_err   = (r_state == ERR);
    assign load_count = r_count;

    // Fetch gating: widened add so a fetch near 2^32 cannot wrap into range
    assign mem_a       = fetch_a;
    assign w_fetch_end = {1'b0, fetch_a} + 33'd3;
    assign w_fetch_ok  = (fetch_a[1:0] == 2'b00) && (w_fetch_end < 33'(DEPTH));
    assign w_run_live  = (r_state == RUN) && !r_cpu_rst;
    assign instr       = (w_run_live && w_fetch_ok) ? mem_rd : NOP;
    assign fetch_fault = w_run_live && !w_fetch_ok;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: directed/randomized bench with a byte-level image model and a RAM model.
// Honours IMEM_LOAD_CHECKSUM_EN when defined for the build.
module tb_imem_load_ctrl;

    localparam int unsigned DEPTH  = 128;
    localparam int unsigned ADDR_W = 7;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_last;
    logic              byte_ready;
    logic              load_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic [31:0]       fetch_a;
    logic [31:0]       mem_a;
    logic [31:0]       mem_rd;
    logic [31:0]       instr;
    logic              fetch_fault;
    logic              cpu_stall;
    logic              cpu_rst;
    logic              load_err;
    logic [ADDR_W:0]   load_count;

    int tests = 0;
    int fails = 0;

    logic [7:0]  img     [0:255];
    logic [7:0]  mdl_mem [0:DEPTH-1];
    logic [7:0]  ram     [0:DEPTH-1];
    logic [14:0] wq      [$];

    imem_load_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .load_req    (load_req),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .fetch_a     (fetch_a),
        .mem_a       (mem_a),
        .mem_rd      (mem_rd),
        .instr       (instr),
        .fetch_fault (fetch_fault),
        .cpu_stall   (cpu_stall),
        .cpu_rst     (cpu_rst),
        .load_err    (load_err),
        .load_count  (load_count)
    );

    always #5 clk = ~clk;

    // Instruction RAM model: byte writes on the clock, combinational word read
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            wq.push_back({mem_waddr, mem_wdata});
            ram[mem_waddr] = mem_wdata;
        end
    end

    always_comb begin
        if ({1'b0, mem_a} + 33'd3 < 33'(DEPTH))
            mem_rd = {ram[7'(mem_a[6:0] + 7'd3)], ram[7'(mem_a[6:0] + 7'd2)],
                      ram[7'(mem_a[6:0] + 7'd1)], ram[mem_a[6:0]]};
        else
            mem_rd = 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bytes(input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_data  = img[i];
            byte_last  = last && (i == n - 1);
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    // Stream img[0..n-1], then compare against the outcome the loading rules predict
    task automatic load_and_check(input string tag, input int n, input bit last);
        int nwr;
        int outc;
        int sum;
        bit done;
        bit is_last;
        nwr = 0; outc = 0; sum = 0; done = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!done) begin
                is_last = last && (i == n - 1);
`ifdef IMEM_LOAD_CHECKSUM_EN
                if (is_last) begin
                    outc = (((sum + int'(img[i])) % 256) == 0) ? 1 : 2;
                    done = 1'b1;
                end else
`endif
                if (nwr == int'(DEPTH)) begin
                    outc = 2;
                    done = 1'b1;
                end else begin
                    nwr++;
                    sum += int'(img[i]);
                    if (is_last) begin
                        outc = 1;
                        done = 1'b1;
                    end
                end
            end
        end
        wq.delete();
        drive_bytes(n, last);
        #1;
        chk({tag, ".count"}, 64'(load_count), 64'(nwr));
        chk({tag, ".stall"}, 64'(cpu_stall), 64'(outc != 1));
        chk({tag, ".err"},   64'(load_err),  64'(outc == 2));
        chk({tag, ".cpurst"}, 64'(cpu_rst),  64'(outc == 1));
        chk({tag, ".instr_gated"}, 64'(instr), 64'(NOP));
        @(posedge clk); #1;
        chk({tag, ".cpurst_drop"}, 64'(cpu_rst), 64'd0);
        chk({tag, ".nwrites"}, 64'(wq.size()), 64'(nwr));
        for (int i = 0; i < nwr && i < wq.size(); i++) begin
            chk({tag, ".wr"}, 64'(wq[i]), 64'({7'(i), img[i]}));
            mdl_mem[i] = img[i];
        end
    endtask

    task automatic pulse_load_req(input string tag);
        load_req = 1'b1;
        #1;
        chk({tag, ".ready_lo"}, 64'(byte_ready), 64'd0);
        @(posedge clk); #1;
        load_req = 1'b0;
        #1;
        chk({tag, ".count0"}, 64'(load_count), 64'd0);
        chk({tag, ".err0"},   64'(load_err),   64'd0);
        chk({tag, ".ready"},  64'(byte_ready), 64'd1);
        chk({tag, ".stall"},  64'(cpu_stall),  64'd1);
    endtask

    task automatic fetch_chk(input logic [31:0] a);
        longint la;
        int ia;
        logic [31:0] ew;
        logic ef;
        la = longint'(a);
        fetch_a = a;
        #1;
        if ((la % 4 == 0) && (la + 3 < longint'(DEPTH))) begin
            ia = int'(la);
            ew = {mdl_mem[ia + 3], mdl_mem[ia + 2], mdl_mem[ia + 1], mdl_mem[ia]};
            ef = 1'b0;
        end else begin
            ew = NOP;
            ef = 1'b1;
        end
        chk("fetch.mem_a", 64'(mem_a), 64'(a));
        chk("fetch.instr", 64'(instr), 64'(ew));
        chk("fetch.fault", 64'(fetch_fault), 64'(ef));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] b;
        int s;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i]     = 8'(i * 7 + 3);
            mdl_mem[i] = 8'(i * 7 + 3);
        end
        reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
        load_req = 1'b0; fetch_a = 32'h0;

        repeat (2) @(posedge clk);
        #1; reset = 1'b0; #1;
        chk("rst.ready",  64'(byte_ready),  64'd1);
        chk("rst.we",     64'(mem_we),      64'd0);
        chk("rst.waddr",  64'(mem_waddr),   64'd0);
        chk("rst.wdata",  64'(mem_wdata),   64'd0);
        chk("rst.stall",  64'(cpu_stall),   64'd1);
        chk("rst.cpurst", 64'(cpu_rst),     64'd0);
        chk("rst.err",    64'(load_err),    64'd0);
        chk("rst.count",  64'(load_count),  64'd0);
        chk("rst.fault",  64'(fetch_fault), 64'd0);
        chk("rst.instr",  64'(instr),       64'(NOP));

        // 84-byte program image, first word addi x1,x0,15
        for (int i = 0; i < 84; i++) img[i] = 8'($urandom);
        img[0] = 8'h93; img[1] = 8'h00; img[2] = 8'hF0; img[3] = 8'h00;
`ifdef IMEM_LOAD_CHECKSUM_EN
        s = 0;
        for (int i = 0; i < 83; i++) s += int'(img[i]);
        img[83] = 8'((256 - (s % 256)) % 256);
`endif
        load_and_check("img84", 84, 1'b1);
        chk("run.instr0", 64'(instr),      64'h0000_0000_00f0_0093);
        chk("run.stall",  64'(cpu_stall),  64'd0);
        chk("run.fault0", 64'(fetch_fault), 64'd0);
        chk("run.ready",  64'(byte_ready), 64'd0);

        fetch_chk(32'd0);
        fetch_chk(32'd2);
        fetch_chk(32'd124);
        fetch_chk(32'd125);
        fetch_chk(32'd128);
        fetch_chk(32'hFFFF_FFFC);
        fetch_chk(32'hFFFF_FFFD);
        for (int i = 0; i < 6; i++) fetch_chk(32'($urandom_range(0, 31) * 4));
        for (int i = 0; i < 3; i++) fetch_chk($urandom);

        // Overflow without last
        pulse_load_req("rq1");
        for (int i = 0; i < 129; i++) img[i] = 8'($urandom);
        load_and_check("ovf", 129, 1'b0);
        chk("ovf.ready", 64'(byte_ready), 64'd0);
        pulse_load_req("rq2");

        // Last byte arriving with memory already full
        for (int i = 0; i < 129; i++) img[i] = 8'($urandom);
        load_and_check("full_last", 129, 1'b1);
        pulse_load_req("rq3");

        // Reset with a write still pending
        for (int i = 0; i < 10; i++) img[i] = 8'($urandom);
        drive_bytes(10, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst.we",    64'(mem_we),     64'd0);
        chk("midrst.count", 64'(load_count), 64'd0);
        reset = 1'b0;
        b = 8'($urandom);
        byte_valid = 1'b1; byte_data = b;
        @(posedge clk); #1;
        byte_valid = 1'b0; #1;
        chk("midrst.we1",   64'(mem_we),    64'd1);
        chk("midrst.addr0", 64'(mem_waddr), 64'd0);
        chk("midrst.data",  64'(mem_wdata), 64'(b));

        // load_req coincident with a byte
        load_req = 1'b1; byte_valid = 1'b1; byte_data = 8'($urandom);
        #1;
        chk("coin.ready", 64'(byte_ready), 64'd0);
        @(posedge clk); #1;
        load_req = 1'b0; byte_valid = 1'b0; #1;
        chk("coin.we",    64'(mem_we),     64'd0);
        chk("coin.count", 64'(load_count), 64'd0);
        b = 8'($urandom);
        byte_valid = 1'b1; byte_data = b;
        @(posedge clk); #1;
        byte_valid = 1'b0; #1;
        chk("coin.we1",   64'(mem_we),     64'd1);
        chk("coin.addr0", 64'(mem_waddr),  64'd0);
        chk("coin.data",  64'(mem_wdata),  64'(b));
        chk("coin.count1", 64'(load_count), 64'd1);

`ifdef IMEM_LOAD_CHECKSUM_EN
        pulse_load_req("rq4");
        img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'hFA;
        load_and_check("cks_ok", 4, 1'b1);
        chk("cks_ok.run", 64'(cpu_stall), 64'd0);
        pulse_load_req("rq5");
        img[3] = 8'hFB;
        load_and_check("cks_bad", 4, 1'b1);
        chk("cks_bad.err", 64'(load_err), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
